// File: rtl/opfetch_pkg.sv
// Shared types for the operand fetch stage: control width, operand source select, load scoreboard state.
// Pure declarations; no latency or backpressure of its own.
package opfetch_pkg;
   localparam int DEF_CTRL_W = 16;

   typedef enum logic [1:0] {
      FWD_ZERO,
      FWD_EX,
      FWD_WB,
      FWD_RF
   } fwd_sel_e;

   typedef enum logic {
      SB_IDLE,
      SB_PEND
   } sb_state_e;
endpackage

// File: rtl/operand_bypass.sv
// One source operand: picks zero / EX forward / WB bypass / register file and flags a load-use hit.
// Purely combinational; the hazard flag is what backpressures the decode side.
module operand_bypass
   import opfetch_pkg::*;
(
   input  logic        i_use,
   input  logic [4:0]  i_idx,
   input  logic [31:0] i_rf_data,
   input  logic        i_ex_vld,
   input  logic [4:0]  i_ex_rd,
   input  logic [31:0] i_ex_data,
   input  logic        i_wb_we,
   input  logic [4:0]  i_wb_rd,
   input  logic [31:0] i_wb_data,
   input  logic        i_ld_out,
   input  logic [4:0]  i_ld_out_rd,
   input  logic        i_ld_pend,
   input  logic [4:0]  i_ld_pend_rd,
   output logic [31:0] o_val,
   output logic        o_hazard
);
   fwd_sel_e w_sel;
   logic     w_wb_hit;
   logic     w_out_hit;
   logic     w_pend_hit;

   assign w_wb_hit = i_wb_we && (i_wb_rd == i_idx);

   always_comb begin
      if (i_idx == 5'd0)
         w_sel = FWD_ZERO;
      else if (i_ex_vld && (i_ex_rd == i_idx))
         w_sel = FWD_EX;
      else if (w_wb_hit)
         w_sel = FWD_WB;
      else
         w_sel = FWD_RF;
   end

   always_comb begin
      case (w_sel)
         FWD_ZERO: o_val = 32'd0;
         FWD_EX:   o_val = i_ex_data;
         FWD_WB:   o_val = i_wb_data;
         default:  o_val = i_rf_data;
      endcase
   end

   // A pending load whose writeback lands this cycle is already covered by the WB bypass.
   assign w_out_hit  = i_ld_out && (i_ld_out_rd == i_idx);
   assign w_pend_hit = i_ld_pend && (i_ld_pend_rd == i_idx) && !w_wb_hit;
   assign o_hazard   = i_use && (i_idx != 5'd0) && (w_out_hit || w_pend_hit);
endmodule

// File: rtl/operand_fetch_stage.sv
// Decode-to-execute operand fetch with bypass and single-load scoreboard; OPFETCH_STALL_CNT_EN adds stall_cnt.
// Latency 1 cycle; in_ready drops on output backpressure, load-use hazard, flush or reset.
module operand_fetch_stage
   import opfetch_pkg::*;
#(
   parameter int CTRL_W = DEF_CTRL_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_pc,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic              in_use_rs1,
   input  logic              in_use_rs2,
   input  logic [4:0]        in_rd,
   input  logic              in_is_load,
   input  logic [31:0]       in_imm,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic [4:0]        rf_rs1_addr,
   output logic [4:0]        rf_rs2_addr,
   input  logic [31:0]       rf_rs1_data,
   input  logic [31:0]       rf_rs2_data,
   input  logic              wb_we,
   input  logic [4:0]        wb_rd,
   input  logic [31:0]       wb_data,
   input  logic              ex_fwd_valid,
   input  logic [4:0]        ex_fwd_rd,
   input  logic [31:0]       ex_fwd_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_pc,
   output logic [31:0]       out_rs1_val,
   output logic [31:0]       out_rs2_val,
   output logic [31:0]       out_imm,
   output logic [4:0]        out_rd,
   output logic              out_is_load,
`ifdef OPFETCH_STALL_CNT_EN
   output logic [31:0]       stall_cnt,
`endif
   output logic [CTRL_W-1:0] out_ctrl
);
   logic              r_out_valid;
   logic [31:0]       r_out_pc;
   logic [31:0]       r_out_rs1_val;
   logic [31:0]       r_out_rs2_val;
   logic [31:0]       r_out_imm;
   logic [4:0]        r_out_rd;
   logic              r_out_is_load;
   logic [CTRL_W-1:0] r_out_ctrl;
   sb_state_e         r_sb_state;
   logic [4:0]        r_ld_pend_rd;

   logic [31:0] w_rs1_val;
   logic [31:0] w_rs2_val;
   logic        w_rs1_haz;
   logic        w_rs2_haz;
   logic        w_hazard;
   logic        w_capture;
   logic        w_ld_out;
   logic        w_ld_pend;
   logic        w_sb_set;
   logic        w_sb_clr;

   assign rf_rs1_addr = in_rs1;
   assign rf_rs2_addr = in_rs2;

   assign w_ld_out  = r_out_valid && r_out_is_load;
   assign w_ld_pend = (r_sb_state == SB_PEND);

   operand_bypass u_byp_rs1 (
      .i_use(in_use_rs1), .i_idx(in_rs1), .i_rf_data(rf_rs1_data),
      .i_ex_vld(ex_fwd_valid), .i_ex_rd(ex_fwd_rd), .i_ex_data(ex_fwd_data),
      .i_wb_we(wb_we), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
      .i_ld_out(w_ld_out), .i_ld_out_rd(r_out_rd),
      .i_ld_pend(w_ld_pend), .i_ld_pend_rd(r_ld_pend_rd),
      .o_val(w_rs1_val), .o_hazard(w_rs1_haz)
   );

   operand_bypass u_byp_rs2 (
      .i_use(in_use_rs2), .i_idx(in_rs2), .i_rf_data(rf_rs2_data),
      .i_ex_vld(ex_fwd_valid), .i_ex_rd(ex_fwd_rd), .i_ex_data(ex_fwd_data),
      .i_wb_we(wb_we), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
      .i_ld_out(w_ld_out), .i_ld_out_rd(r_out_rd),
      .i_ld_pend(w_ld_pend), .i_ld_pend_rd(r_ld_pend_rd),
      .o_val(w_rs2_val), .o_hazard(w_rs2_haz)
   );

   // The load term keeps at most one load past this stage at a time.
   assign w_hazard  = w_rs1_haz || w_rs2_haz || (in_is_load && (w_ld_pend || w_ld_out));
   assign in_ready  = rst_n && (!r_out_valid || out_ready) && !w_hazard && !flush;
   assign w_capture = in_valid && in_ready;
   assign w_sb_set  = r_out_valid && out_ready && r_out_is_load && (r_out_rd != 5'd0);
   assign w_sb_clr  = w_ld_pend && wb_we && (wb_rd == r_ld_pend_rd);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_valid   <= 1'b0;
         r_out_pc      <= '0;
         r_out_rs1_val <= '0;
         r_out_rs2_val <= '0;
         r_out_imm     <= '0;
         r_out_rd      <= '0;
         r_out_is_load <= 1'b0;
         r_out_ctrl    <= '0;
      end else if (flush) begin
         r_out_valid <= 1'b0;
      end else if (w_capture) begin
         r_out_valid   <= 1'b1;
         r_out_pc      <= in_pc;
         r_out_rs1_val <= w_rs1_val;
         r_out_rs2_val <= w_rs2_val;
         r_out_imm     <= in_imm;
         r_out_rd      <= in_rd;
         r_out_is_load <= in_is_load;
         r_out_ctrl    <= in_ctrl;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   // Flush leaves the scoreboard alone: the issued load is older than the flushing branch.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sb_state   <= SB_IDLE;
         r_ld_pend_rd <= '0;
      end else if (w_sb_set) begin
         r_sb_state   <= SB_PEND;
         r_ld_pend_rd <= r_out_rd;
      end else if (w_sb_clr) begin
         r_sb_state <= SB_IDLE;
      end
   end

`ifdef OPFETCH_STALL_CNT_EN
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_stall_cnt <= '0;
      else if (in_valid && w_hazard && !flush && (r_stall_cnt != 32'hFFFF_FFFF))
         r_stall_cnt <= r_stall_cnt + 32'd1;
   end

   assign stall_cnt = r_stall_cnt;
`endif

   assign out_valid   = r_out_valid;
   assign out_pc      = r_out_pc;
   assign out_rs1_val = r_out_rs1_val;
   assign out_rs2_val = r_out_rs2_val;
   assign out_imm     = r_out_imm;
   assign out_rd      = r_out_rd;
   assign out_is_load = r_out_is_load;
   assign out_ctrl    = r_out_ctrl;
endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed vectors, a register-file/hazard model, and a per-cycle compare.
// Build with OPFETCH_STALL_CNT_EN defined to also check stall_cnt.
module tb_operand_fetch_stage;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [31:0] in_pc, in_imm;
   logic [4:0]  in_rs1, in_rs2, in_rd;
   logic        in_use_rs1, in_use_rs2, in_is_load;
   logic [15:0] in_ctrl;
   logic [4:0]  rf_rs1_addr, rf_rs2_addr;
   logic [31:0] rf_rs1_data, rf_rs2_data;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        ex_fwd_valid;
   logic [4:0]  ex_fwd_rd;
   logic [31:0] ex_fwd_data;
   logic        flush;
   logic        out_valid, out_ready, out_is_load;
   logic [31:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
   logic [4:0]  out_rd;
   logic [15:0] out_ctrl;
`ifdef OPFETCH_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   operand_fetch_stage #(.CTRL_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
      .in_rd(in_rd), .in_is_load(in_is_load), .in_imm(in_imm), .in_ctrl(in_ctrl),
      .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
      .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .ex_fwd_valid(ex_fwd_valid), .ex_fwd_rd(ex_fwd_rd), .ex_fwd_data(ex_fwd_data),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_imm(out_imm),
      .out_rd(out_rd), .out_is_load(out_is_load),
`ifdef OPFETCH_STALL_CNT_EN
      .stall_cnt(stall_cnt),
`endif
      .out_ctrl(out_ctrl)
   );

   // Bench-side register file: asynchronous read, old value on a same-cycle write.
   logic [31:0] rf [32];
   assign rf_rs1_data = (rf_rs1_addr == 5'd0) ? 32'd0 : rf[rf_rs1_addr];
   assign rf_rs2_data = (rf_rs2_addr == 5'd0) ? 32'd0 : rf[rf_rs2_addr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state: what execute should be holding, and which load result is still outstanding.
   bit          chk_en = 1'b0;
   bit          m_vld, m_ld, m_pend, m_set, m_hz, m_rdy;
   logic [31:0] m_pc, m_a, m_b, m_imm;
   logic [4:0]  m_rd, m_pend_rd;
   logic [15:0] m_ctrl;
`ifdef OPFETCH_STALL_CNT_EN
   logic [31:0] m_stall;
`endif

   function automatic bit unavailable(input logic [4:0] r);
      if (r == 5'd0) return 1'b0;
      if (m_vld && m_ld && m_rd == r) return 1'b1;
      if (m_pend && m_pend_rd == r && !(wb_we && wb_rd == r)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit m_hazard();
      bit load_busy = m_pend || (m_vld && m_ld);
      return (in_use_rs1 && unavailable(in_rs1)) || (in_use_rs2 && unavailable(in_rs2))
             || (in_is_load && load_busy);
   endfunction

   function automatic bit m_ready();
      return rst_n && (!m_vld || out_ready) && !m_hazard() && !flush;
   endfunction

   function automatic logic [31:0] m_operand(input logic [4:0] r);
      if (r == 5'd0) return 32'd0;
      if (ex_fwd_valid && ex_fwd_rd == r) return ex_fwd_data;
      if (wb_we && wb_rd == r) return wb_data;
      return rf[r];
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         chk_en = 1'b1;
         m_vld = 1'b0; m_ld = 1'b0; m_pend = 1'b0; m_pend_rd = '0;
         m_pc = '0; m_a = '0; m_b = '0; m_imm = '0; m_rd = '0; m_ctrl = '0;
`ifdef OPFETCH_STALL_CNT_EN
         m_stall = '0;
`endif
      end else begin
         m_hz  = m_hazard();
         m_rdy = m_ready();
`ifdef OPFETCH_STALL_CNT_EN
         if (in_valid && m_hz && !flush && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
`endif
         m_set = m_vld && out_ready && m_ld && (m_rd != 5'd0);
         if (m_set) begin
            m_pend = 1'b1; m_pend_rd = m_rd;
         end else if (m_pend && wb_we && wb_rd == m_pend_rd) begin
            m_pend = 1'b0;
         end
         if (flush) m_vld = 1'b0;
         else if (in_valid && m_rdy) begin
            m_vld = 1'b1; m_pc = in_pc; m_a = m_operand(in_rs1); m_b = m_operand(in_rs2);
            m_imm = in_imm; m_rd = in_rd; m_ld = in_is_load; m_ctrl = in_ctrl;
         end else if (out_ready) m_vld = 1'b0;
      end
      if (wb_we && wb_rd != 5'd0) rf[wb_rd] <= wb_data;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_out_valid", 32'(out_valid), 32'(m_vld));
         chk("m_in_ready", 32'(in_ready), 32'(m_ready()));
         chk("m_out_pc", out_pc, m_pc);
         chk("m_out_rs1", out_rs1_val, m_a);
         chk("m_out_rs2", out_rs2_val, m_b);
         chk("m_out_imm", out_imm, m_imm);
         chk("m_out_rd", 32'(out_rd), 32'(m_rd));
         chk("m_out_is_load", 32'(out_is_load), 32'(m_ld));
         chk("m_out_ctrl", 32'(out_ctrl), 32'(m_ctrl));
`ifdef OPFETCH_STALL_CNT_EN
         chk("m_stall_cnt", stall_cnt, m_stall);
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd, input logic ld);
      in_valid = 1'b1; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2;
      in_use_rs1 = u1; in_use_rs2 = u2; in_rd = rd; in_is_load = ld;
      in_imm = pc ^ 32'h0F0F_0000; in_ctrl = pc[15:0] ^ 16'hA5A5;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
      rf[5] = 32'h11;
      rst_n = 1'b0; in_valid = 1'b0; in_pc = '0; in_rs1 = '0; in_rs2 = '0;
      in_use_rs1 = 1'b0; in_use_rs2 = 1'b0; in_rd = '0; in_is_load = 1'b0; in_imm = '0; in_ctrl = '0;
      wb_we = 1'b0; wb_rd = '0; wb_data = '0; ex_fwd_valid = 1'b0; ex_fwd_rd = '0; ex_fwd_data = '0;
      flush = 1'b0; out_ready = 1'b1;

      tick(); tick();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_rs1_val", out_rs1_val, 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      rst_n = 1'b1; #1;
      chk("rel_in_ready", 32'(in_ready), 32'd1);

      // Writeback in the capture cycle beats the stale register-file value.
      issue(32'h100, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b0);
      wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h22;
      tick(); wb_we = 1'b0;
      chk("wb_byp_valid", 32'(out_valid), 32'd1);
      chk("wb_byp_rs1", out_rs1_val, 32'h22);
      chk("wb_byp_rs2", out_rs2_val, 32'd0);

      // EX forward outranks WB for the same register.
      issue(32'h104, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b0);
      ex_fwd_valid = 1'b1; ex_fwd_rd = 5'd7; ex_fwd_data = 32'hAA;
      wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'hBB;
      tick(); ex_fwd_valid = 1'b0; wb_we = 1'b0;
      chk("ex_prio_rs1", out_rs1_val, 32'hAA);
      chk("ex_prio_rs2", out_rs2_val, 32'hAA);
      chk("ex_prio_pc", out_pc, 32'h104);

      // lw x3 then add x4,x3,x3: two stall cycles, capture on the wb cycle.
      issue(32'h108, 5'd0, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1);
      tick();
      chk("lw_is_load", 32'(out_is_load), 32'd1);
      issue(32'h10C, 5'd3, 5'd3, 1'b1, 1'b1, 5'd4, 1'b0); #1;
      chk("lu_stall0", 32'(in_ready), 32'd0);
      tick();
      chk("lu_stall1", 32'(in_ready), 32'd0);
      tick();
      wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h1234; #1;
      chk("lu_wb_ready", 32'(in_ready), 32'd1);
      tick(); wb_we = 1'b0; in_valid = 1'b0;
      chk("lu_rs1", out_rs1_val, 32'h1234);
      chk("lu_rs2", out_rs2_val, 32'h1234);
      chk("lu_pc", out_pc, 32'h10C);
`ifdef OPFETCH_STALL_CNT_EN
      chk("lu_stall_cnt", stall_cnt, 32'd2);
`endif

      // x0 ignores forwarding; an unused source never matches a pending load.
      issue(32'h110, 5'd0, 5'd0, 1'b1, 1'b1, 5'd10, 1'b0);
      ex_fwd_valid = 1'b1; ex_fwd_rd = 5'd0; ex_fwd_data = 32'hFF;
      tick(); ex_fwd_valid = 1'b0;
      chk("x0_rs1", out_rs1_val, 32'd0);
      chk("x0_rs2", out_rs2_val, 32'd0);
      issue(32'h114, 5'd0, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1);
      tick(); in_valid = 1'b0;
      tick();
      issue(32'h118, 5'd1, 5'd9, 1'b1, 1'b0, 5'd11, 1'b0); #1;
      chk("unused_ready", 32'(in_ready), 32'd1);
      tick();
      chk("unused_pc", out_pc, 32'h118);
      chk("unused_rs1", out_rs1_val, 32'h1001);

      // Flush empties a held slot without capturing; the x9 load stays pending.
      out_ready = 1'b0; in_valid = 1'b0;
      tick();
      chk("hold_valid", 32'(out_valid), 32'd1);
      issue(32'h200, 5'd1, 5'd1, 1'b1, 1'b1, 5'd20, 1'b0); flush = 1'b1; #1;
      chk("flush_ready", 32'(in_ready), 32'd0);
      tick(); flush = 1'b0;
      chk("flush_valid", 32'(out_valid), 32'd0);
      out_ready = 1'b1;
      issue(32'h120, 5'd9, 5'd0, 1'b1, 1'b0, 5'd12, 1'b0); #1;
      chk("pend_survive", 32'(in_ready), 32'd0);
      tick();
      chk("pend_stall_valid", 32'(out_valid), 32'd0);
      wb_we = 1'b1; wb_rd = 5'd9; wb_data = 32'h9999; #1;
      chk("pend_wb_ready", 32'(in_ready), 32'd1);
      tick(); wb_we = 1'b0;
      chk("pend_rs1", out_rs1_val, 32'h9999);
      chk("pend_pc", out_pc, 32'h120);
`ifdef OPFETCH_STALL_CNT_EN
      chk("pend_stall_cnt", stall_cnt, 32'd3);
`endif

      // Second load blocked while one is in flight; reset mid-stall drops everything.
      issue(32'h124, 5'd0, 5'd0, 1'b1, 1'b0, 5'd13, 1'b1);
      tick();
      issue(32'h12C, 5'd0, 5'd0, 1'b1, 1'b0, 5'd14, 1'b1); #1;
      chk("ld_ld_ready", 32'(in_ready), 32'd0);
      in_valid = 1'b0;
      tick();
      issue(32'h12C, 5'd0, 5'd0, 1'b1, 1'b0, 5'd14, 1'b1); #1;
      chk("ld_pend_ready", 32'(in_ready), 32'd0);
      issue(32'h128, 5'd13, 5'd0, 1'b1, 1'b0, 5'd15, 1'b0);
      tick();
      rst_n = 1'b0;
      tick();
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_ready", 32'(in_ready), 32'd0);
      rst_n = 1'b1; #1;
      chk("post_rst_ready", 32'(in_ready), 32'd1);
      tick(); in_valid = 1'b0;
      chk("post_rst_pc", out_pc, 32'h128);
      chk("post_rst_rs1", out_rs1_val, 32'h100D);
`ifdef OPFETCH_STALL_CNT_EN
      chk("post_rst_stall_cnt", stall_cnt, 32'd0);
`endif
      tick(); tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/operand_fetch_stage.md
# operand_fetch_stage

Decode-to-execute pipeline stage of the RV32 core. It takes one decoded instruction per cycle over a valid/ready handshake and drives the register file's two read addresses. It resolves each source operand from the register file, the writeback port, or the EX forward path, and detects load-use hazards with a single-entry load scoreboard. It then presents registered operands to execute.

## Interface
Parameters:
- CTRL_W, 16, width of the opaque decoded-control bundle passed through to execute

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  reset; synchronous, active-low
- in_valid  in  1  decoded instruction available
- in_ready  out  1  stage accepts instruction this cycle
- in_pc  in  32  instruction PC
- in_rs1 / in_rs2  in  5  source register indices
- in_use_rs1 / in_use_rs2  in  1  source actually read by instruction
- in_rd  in  5  destination index
- in_is_load  in  1  instruction is a load
- in_imm  in  32  decoded immediate
- in_ctrl  in  CTRL_W  control bundle
- rf_rs1_addr / rf_rs2_addr  out  5  register file read addresses (combinational = in_rs1/in_rs2)
- rf_rs1_data / rf_rs2_data  in  32  register file read data (asynchronous read, x0 reads 0)
- wb_we, wb_rd, wb_data  in  1/5/32  register file write port, observed for bypass and scoreboard clear
- ex_fwd_valid, ex_fwd_rd, ex_fwd_data  in  1/5/32  non-load result from the EX/MEM register
- flush  in  1  kill the instruction held in this stage
- out_valid  out  1  operands valid to execute
- out_ready  in  1  execute accepts
- out_pc, out_rs1_val, out_rs2_val, out_imm  out  32 each  registered operands
- out_rd  out  5; out_is_load  out  1; out_ctrl  out  CTRL_W
- stall_cnt  out  32  hazard-stall cycle count (present only with OPFETCH_STALL_CNT_EN)

## Operation
- Output register: EMPTY (out_valid=0) / FULL (out_valid=1).
- Capture when in_valid && in_ready.
- FULL→EMPTY on out_ready && no capture. Flush forces EMPTY, and no capture occurs in a flush cycle.
- Operand select, per source, in priority order:
  - index 0 → 0
  - ex_fwd_valid && ex_fwd_rd==index → ex_fwd_data
  - wb_we && wb_rd==index → wb_data (covers same-cycle write, since the register file returns the old value)
  - otherwise rf data
- Load scoreboard (IDLE/PEND, ld_pend_rd):
  - IDLE→PEND when out_valid && out_ready && out_is_load && out_rd!=0.
  - PEND→IDLE when wb_we && wb_rd==ld_pend_rd.
  - If set and clear occur in the same cycle, set wins.
  - Flush does not clear PEND, because the issued load is older than the flushing branch.
- hazard is true if any of the following hold:
  - A used source (index≠0) equals out_rd while out_valid && out_is_load.
  - A used source equals ld_pend_rd while in PEND and no same-cycle wb clear hits it.
  - in_is_load && (PEND || (out_valid && out_is_load)), which keeps at most one load in flight past this stage.
- in_ready = (!out_valid || out_ready) && !hazard && !flush.
- Unused sources (in_use_rsX=0) never cause a hazard.

## Timing
- Latency: capture at edge N, out_* valid after edge N; one instruction per cycle at full throughput.
- in_ready and rf_*_addr are combinational. All out_* signals are registered.
- Reset (rst_n=0 at an edge):
  - out_valid=0, all out_* data=0, scoreboard IDLE, ld_pend_rd=0, stall_cnt=0.
  - While rst_n=0, in_ready=0.
- Reset asserted mid-stall discards the held instruction and the pending load.
- Back-to-back load then dependent use: the use stalls until the load's wb cycle and captures wb_data in that cycle.

## Configuration
- OPFETCH_STALL_CNT_EN defined:
  - stall_cnt increments on each cycle with in_valid && hazard && !flush.
  - The count saturates at 32'hFFFF_FFFF.
- Not defined: stall_cnt port and counter are absent, and the rest of the behaviour is identical.

## Structure
- Package opfetch_pkg: CTRL_W default, fwd_sel_e enum (FWD_ZERO, FWD_EX, FWD_WB, FWD_RF), and a scoreboard state typedef.
- Sub-module operand_bypass, instantiated twice, one per source: index, use flag, rf/ex/wb inputs → value and hazard match.

## Test plan
- Reset: hold rst_n=0 for 2 cycles → out_valid=0, out_rs1_val=0, in_ready=0, then in_ready=1 after release.
- WB bypass: x5 holds 0x11, wb writes x5=0x22 in the capture cycle, instruction reads x5 → out_rs1_val=0x22.
- EX priority: ex_fwd x7=0xAA and wb x7=0xBB in the same cycle, instruction reads x7 → 0xAA.
- Load-use: `lw x3` issues, then `add x4,x3,x3` arrives → in_ready=0 until wb x3=0x1234, capture in that cycle with both operands 0x1234, stall_cnt equals the stalled cycle count.
- x0 and unused sources: ex_fwd x0=0xFF and a read of x0 → 0. A pending load to x9 with in_use_rs2=0, rs2=9 → no stall.
- Flush: FULL with out_ready=0 plus flush → out_valid=0 next cycle. A pending load scoreboard survives, and a dependent instruction still stalls until its wb.
